multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel countdown timer for the anti-theft controller; it replaces the single fixed-width countdown used for the arming, entry and alarm delays. Each of `N_CH` independent channels counts down a `CNT_W`-bit value on a shared slow tick enable, supports one-shot or periodic (auto-reload) mode, can be held or aborted, and reports a one-cycle expiry pulse plus a sticky expiry flag. The block sits between the 1 Hz enable divider and the alarm/arming FSM.

## Interface
- `N_CH`, 4, number of independent channels (1–16)
- `CNT_W`, 8, count width per channel (2–16)
- `clk` in 1: single system clock (fast, e.g. 25 MHz)
- `rst` in 1: reset; asynchronous, active-high
- `tick_en` in 1: slow enable pulse, one `clk` cycle wide, shared by all channels
- `start` in N_CH: per-channel load-and-run request
- `periodic` in N_CH: mode, sampled on `start`; 0 = one-shot, 1 = auto-reload
- `load_value` in N_CH*CNT_W: channel i occupies bits [i*CNT_W +: CNT_W]
- `hold` in N_CH: freeze channel; ticks are ignored while high
- `abort` in N_CH: stop channel and clear its state
- `clear_expired` in N_CH: clear the sticky expiry flag
- `count` out N_CH*CNT_W: remaining count per channel, same packing as `load_value`
- `running` out N_CH: channel is counting
- `expired` out N_CH: sticky expiry flag
- `expired_pulse` out N_CH: one-cycle pulse on each expiry
- `any_expired` out 1: OR of `expired`

## Operation
- Per-channel state: `IDLE` (running=0) and `RUN` (running=1). Registers: count, reload, mode, running, expired, expired_pulse.
- Priority per channel, per cycle: `abort` > `start` > tick processing.
- `abort`: go to `IDLE`; count=0; expired=0; expired_pulse=0.
- `start` with load N≥1: go to `RUN`; count=N; reload=N; mode=`periodic[i]`; expired=0. A `tick_en` in the same cycle is ignored.
- `start` with load 0: stay in or go to `IDLE`; count=0; expired=1; expired_pulse=1 on the next cycle. This is an immediate expiry.
- Tick processing in `RUN`, when `tick_en`=1 and `hold[i]`=0:
  - count>1: count decrements by 1.
  - count==1, one-shot: count=0; go to `IDLE`; expired=1; expired_pulse=1.
  - count==1, periodic: count=reload; stay in `RUN`; expired=1; expired_pulse=1.
- A start value of N therefore expires on exactly the Nth accepted tick after start.
- `expired_pulse` is high for exactly one cycle and is otherwise 0.
- `clear_expired` clears `expired`. If an expiry occurs in the same cycle, the set wins.
- `hold` in `IDLE` has no effect. `hold` does not block `start` or `abort`.
- Arithmetic is unsigned and modulo-free: count never wraps below 0 and never exceeds reload.
- Channels are fully independent. There is no shared state apart from `tick_en`.

## Timing
- All outputs are registered. Reset value of every output and internal register is 0, including `any_expired`.
- `start` at edge k: `count`=load and `running`=1 are visible after edge k.
- Expiry tick at edge k: `expired`, `expired_pulse` and `any_expired` are visible after edge k. `any_expired` is a registered OR, so it updates at the same edge as `expired`, not one cycle later.
- `rst` asserted mid-count forces all state to 0 immediately (asynchronously). Counting resumes only on a new `start`.
- Back-to-back `start` restarts the countdown from the new value. No pending expiry is produced.

## Structure
- Package `timer_pkg`:
  - `timer_mode_e` (`MODE_ONESHOT`, `MODE_PERIODIC`)
  - `timer_state_e` (`T_IDLE`, `T_RUN`)
  - default width constants
- Sub-module `timer_channel` (parameter `CNT_W`): one channel's state machine.
- `multi_timer` instantiates `N_CH` copies in a generate loop, handles the flattened bus packing and registers `any_expired`.

## Test plan
- N_CH=4, CNT_W=8; ch0 start load 3, one-shot, tick every 10 cycles -> count 3,2,1,0; `expired_pulse` on the 3rd tick only; `running`=0 and `expired`=1 afterwards.
- ch1 start load 2, periodic, 5 ticks -> count 2,1,2,1,2,1; pulses on ticks 2 and 4; `running` stays 1.
- ch2 start load 5, hold high across 3 ticks, then release -> count stays 5 during hold; expires on the 5th unheld tick.
- ch3 start load 0 -> `expired`=1 and one `expired_pulse` next cycle; `running`=0. Then `clear_expired` in the same cycle as a ch0 expiry -> ch3 flag clears, ch0 flag sets, `any_expired`=1.
- ch0 start 4, abort after 2 ticks, with `start` and `tick_en` also high in the abort cycle -> abort wins; count=0; no pulse. A `start` with a coincident tick loads without decrementing.
- ch1 running at count 7, `rst` pulsed between clock edges -> all outputs 0 immediately; no expiry after rst release until a new start.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg
// Shared types and default sizes for the multi-channel countdown timer.
//   timer_mode_e  : one-shot or auto-reload behaviour of a channel
//   timer_state_e : per-channel state encoding (IDLE / RUN)
//   DEF_N_CH, DEF_CNT_W : default channel count and count width
package timer_pkg;

    typedef enum logic [0:0] {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } timer_mode_e;

    typedef enum logic [0:0] {
        T_IDLE = 1'b0,
        T_RUN  = 1'b1
    } timer_state_e;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/timer_channel.sv
// timer_channel
// One countdown channel. Counts down on accepted ticks, expires on the
// Nth accepted tick after a start with value N, optionally reloads.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   tick_en           : shared slow enable pulse
//   start, periodic   : load-and-run request and mode sampled with it
//   load_value        : start value (0 means expire immediately)
//   hold              : ignore ticks while high
//   abort             : return to IDLE and clear everything
//   clear_expired     : clear the sticky expiry flag
//   count             : remaining count
//   running           : channel state (1 = RUN, 0 = IDLE)
//   expired           : sticky expiry flag
//   expired_pulse     : one-cycle pulse per expiry
//   expired_next      : next-cycle value of expired, so the parent can
//                       register an OR that lines up with expired
//
// Handshake: none; every request input is a level sampled on the rising
// edge and acts in that cycle, with priority abort > start > tick.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_en,
    input  logic             start,
    input  logic             periodic,
    input  logic [CNT_W-1:0] load_value,
    input  logic             hold,
    input  logic             abort,
    input  logic             clear_expired,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             expired_pulse,
    output logic             expired_next
);

    localparam logic [0:0] ST_IDLE = T_IDLE;
    localparam logic [0:0] ST_RUN  = T_RUN;

    logic [0:0]       state_q,   state_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [CNT_W-1:0] reload_q,  reload_d;
    timer_mode_e      mode_q,    mode_d;
    logic             expired_q, expired_d;
    logic             pulse_q,   pulse_d;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        mode_d    = mode_q;
        expired_d = expired_q;
        pulse_d   = 1'b0;

        if (abort) begin
            state_d   = ST_IDLE;
            count_d   = '0;
            reload_d  = '0;
            mode_d    = MODE_ONESHOT;
            expired_d = 1'b0;
        end else if (start) begin
            // A tick coinciding with start is deliberately dropped.
            if (load_value != '0) begin
                state_d   = ST_RUN;
                count_d   = load_value;
                reload_d  = load_value;
                mode_d    = periodic ? MODE_PERIODIC : MODE_ONESHOT;
                expired_d = 1'b0;
            end else begin
                // Zero load: expire at once without ever running.
                state_d   = ST_IDLE;
                count_d   = '0;
                reload_d  = '0;
                mode_d    = periodic ? MODE_PERIODIC : MODE_ONESHOT;
                expired_d = 1'b1;
                pulse_d   = 1'b1;
            end
        end else begin
            if (clear_expired) begin
                expired_d = 1'b0;
            end
            // An expiry below overrides the clear above (set wins).
            if (state_q == ST_RUN && tick_en && !hold) begin
                if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    expired_d = 1'b1;
                    pulse_d   = 1'b1;
                    if (mode_q == MODE_PERIODIC) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            mode_q    <= MODE_ONESHOT;
            expired_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            expired_q <= expired_d;
            pulse_q   <= pulse_d;
        end
    end

    assign count         = count_q;
    assign running       = (state_q == ST_RUN);
    assign expired       = expired_q;
    assign expired_pulse = pulse_q;
    assign expired_next  = expired_d;

endmodule

// File: rtl/multi_timer.sv
// multi_timer
// N_CH independent countdown channels sharing one slow tick enable.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   tick_en         : shared slow enable pulse (one clk wide)
//   start, periodic, hold, abort, clear_expired : per-channel controls
//   load_value      : channel i at bits [i*CNT_W +: CNT_W]
//   count           : remaining count per channel, same packing
//   running         : per-channel state (1 = RUN)
//   expired         : sticky expiry flags
//   expired_pulse   : one-cycle expiry pulses
//   any_expired     : registered OR of expired, aligned with expired
module multi_timer
    import timer_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_en,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       periodic,
    input  logic [N_CH*CNT_W-1:0] load_value,
    input  logic [N_CH-1:0]       hold,
    input  logic [N_CH-1:0]       abort,
    input  logic [N_CH-1:0]       clear_expired,
    output logic [N_CH*CNT_W-1:0] count,
    output logic [N_CH-1:0]       running,
    output logic [N_CH-1:0]       expired,
    output logic [N_CH-1:0]       expired_pulse,
    output logic                  any_expired
);

    logic [N_CH-1:0] expired_next;
    logic            any_expired_q, any_expired_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .tick_en      (tick_en),
            .start        (start[i]),
            .periodic     (periodic[i]),
            .load_value   (load_value[i*CNT_W +: CNT_W]),
            .hold         (hold[i]),
            .abort        (abort[i]),
            .clear_expired(clear_expired[i]),
            .count        (count[i*CNT_W +: CNT_W]),
            .running      (running[i]),
            .expired      (expired[i]),
            .expired_pulse(expired_pulse[i]),
            .expired_next (expired_next[i])
        );
    end

    // OR the channels' next-state flags so the registered result changes
    // on the same edge as the flags themselves.
    always_comb begin
        any_expired_d = |expired_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_expired_q <= 1'b0;
        end else begin
            any_expired_q <= any_expired_d;
        end
    end

    assign any_expired = any_expired_q;

endmodule

// File: tb/tb_multi_timer.sv
module tb_multi_timer;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;

    logic                  clk;
    logic                  rst;
    logic                  tick_en;
    logic [N_CH-1:0]       start;
    logic [N_CH-1:0]       periodic;
    logic [N_CH*CNT_W-1:0] load_value;
    logic [N_CH-1:0]       hold;
    logic [N_CH-1:0]       abort;
    logic [N_CH-1:0]       clear_expired;
    logic [N_CH*CNT_W-1:0] count;
    logic [N_CH-1:0]       running;
    logic [N_CH-1:0]       expired;
    logic [N_CH-1:0]       expired_pulse;
    logic                  any_expired;

    int n_total = 0;
    int n_bad   = 0;
    logic [8:0] exp_q[$];

    multi_timer #(
        .N_CH (N_CH),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_en      (tick_en),
        .start        (start),
        .periodic     (periodic),
        .load_value   (load_value),
        .hold         (hold),
        .abort        (abort),
        .clear_expired(clear_expired),
        .count        (count),
        .running      (running),
        .expired      (expired),
        .expired_pulse(expired_pulse),
        .any_expired  (any_expired)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return count[ch*CNT_W +: CNT_W];
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change just after the falling edge; outputs are sampled at the
    // next falling edge, half a period after the active edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start(input int ch, input logic [CNT_W-1:0] val, input logic per);
        start[ch] = 1'b1;
        periodic[ch] = per;
        load_value[ch*CNT_W +: CNT_W] = val;
        cycle();
        start[ch] = 1'b0;
        periodic[ch] = 1'b0;
    endtask

    task automatic do_tick();
        tick_en = 1'b1;
        cycle();
        tick_en = 1'b0;
    endtask

    task automatic spaced_tick();
        repeat (9) cycle();
        do_tick();
    endtask

    task automatic do_abort(input int ch);
        abort[ch] = 1'b1;
        cycle();
        abort[ch] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [8:0] e;
        logic       seen;

        rst = 1'b1;
        tick_en = 1'b0;
        start = '0;
        periodic = '0;
        load_value = '0;
        hold = '0;
        abort = '0;
        clear_expired = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset state
        check("rst_count", count, 0);
        check("rst_running", running, 0);
        check("rst_expired", expired, 0);
        check("rst_pulse", expired_pulse, 0);
        check("rst_any", any_expired, 0);

        // ch0 one-shot 3, tick every 10 cycles
        do_start(0, 8'd3, 1'b0);
        check("os_cnt_start", cnt_of(0), 3);
        check("os_run_start", running[0], 1);
        spaced_tick();
        check("os_cnt_t1", cnt_of(0), 2);
        check("os_pulse_t1", expired_pulse[0], 0);
        spaced_tick();
        check("os_cnt_t2", cnt_of(0), 1);
        check("os_pulse_t2", expired_pulse[0], 0);
        spaced_tick();
        check("os_cnt_t3", cnt_of(0), 0);
        check("os_pulse_t3", expired_pulse, 4'b0001);
        check("os_exp_t3", expired, 4'b0001);
        check("os_run_t3", running[0], 0);
        check("os_any_t3", any_expired, 1);
        cycle();
        check("os_pulse_after", expired_pulse[0], 0);
        check("os_exp_after", expired[0], 1);
        clear_expired[0] = 1'b1;
        cycle();
        clear_expired[0] = 1'b0;
        check("os_clr_exp", expired, 0);
        check("os_clr_any", any_expired, 0);

        // ch1 periodic 2, five ticks: {pulse,count}
        do_start(1, 8'd2, 1'b1);
        check("per_cnt_start", cnt_of(1), 2);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h102);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h102);
        exp_q.push_back(9'h001);
        for (int k = 0; k < 5; k++) begin
            do_tick();
            e = exp_q.pop_front();
            check("per_pulse_cnt", {expired_pulse[1], cnt_of(1)}, e);
            check("per_running", running[1], 1);
        end
        check("per_sticky", expired[1], 1);
        do_abort(1);
        check("per_abort_cnt", cnt_of(1), 0);
        check("per_abort_run", running[1], 0);
        check("per_abort_exp", expired[1], 0);
        check("per_abort_any", any_expired, 0);

        // ch2 load 5 with hold for three ticks
        hold[2] = 1'b1;
        do_start(2, 8'd5, 1'b0);
        check("hold_cnt_start", cnt_of(2), 5);
        for (int k = 0; k < 3; k++) begin
            do_tick();
            check("hold_cnt_frozen", cnt_of(2), 5);
        end
        hold[2] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            do_tick();
            check("hold_cnt_rel", cnt_of(2), 5 - k);
            check("hold_pulse_rel", expired_pulse[2], 0);
        end
        do_tick();
        check("hold_cnt_exp", cnt_of(2), 0);
        check("hold_pulse_exp", expired_pulse[2], 1);
        check("hold_exp_flag", expired[2], 1);
        do_abort(2);
        check("hold_abort_exp", expired[2], 0);

        // ch3 load 0 -> immediate expiry
        do_start(3, 8'd0, 1'b0);
        check("zero_exp", expired, 4'b1000);
        check("zero_pulse", expired_pulse, 4'b1000);
        check("zero_run", running[3], 0);
        check("zero_cnt", cnt_of(3), 0);
        check("zero_any", any_expired, 1);
        cycle();
        check("zero_pulse_gone", expired_pulse[3], 0);
        // clear ch3 in the same cycle ch0 expires
        do_start(0, 8'd1, 1'b0);
        tick_en = 1'b1;
        clear_expired[3] = 1'b1;
        cycle();
        tick_en = 1'b0;
        clear_expired[3] = 1'b0;
        check("clrx_exp", expired, 4'b0001);
        check("clrx_pulse", expired_pulse, 4'b0001);
        check("clrx_any", any_expired, 1);
        // clear on the same channel as an expiry: set wins
        do_start(1, 8'd1, 1'b1);
        do_tick();
        tick_en = 1'b1;
        clear_expired[1] = 1'b1;
        cycle();
        tick_en = 1'b0;
        clear_expired[1] = 1'b0;
        check("setwin_exp1", expired[1], 1);
        check("setwin_cnt1", cnt_of(1), 1);
        abort[0] = 1'b1;
        abort[1] = 1'b1;
        cycle();
        abort = '0;
        check("tidy_any", any_expired, 0);

        // ch0 abort beats start and tick
        do_start(0, 8'd4, 1'b0);
        do_tick();
        do_tick();
        check("abt_cnt_pre", cnt_of(0), 2);
        abort[0] = 1'b1;
        start[0] = 1'b1;
        load_value[7:0] = 8'd9;
        tick_en = 1'b1;
        cycle();
        abort[0] = 1'b0;
        start[0] = 1'b0;
        tick_en = 1'b0;
        check("abt_cnt", cnt_of(0), 0);
        check("abt_run", running[0], 0);
        check("abt_pulse", expired_pulse[0], 0);
        check("abt_exp", expired[0], 0);
        // start with coincident tick loads undecremented
        start[0] = 1'b1;
        load_value[7:0] = 8'd6;
        tick_en = 1'b1;
        cycle();
        start[0] = 1'b0;
        tick_en = 1'b0;
        check("st_tick_cnt", cnt_of(0), 6);
        // back-to-back restart
        do_start(0, 8'd3, 1'b0);
        check("b2b_cnt", cnt_of(0), 3);
        check("b2b_pulse", expired_pulse[0], 0);
        do_tick();
        do_tick();
        check("b2b_no_early", expired_pulse[0], 0);
        do_tick();
        check("b2b_pulse_t3", expired_pulse[0], 1);
        do_abort(0);

        // asynchronous reset mid-count
        do_start(1, 8'd7, 1'b0);
        check("arst_cnt_pre", cnt_of(1), 7);
        #2 rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_running", running, 0);
        check("arst_expired", expired, 0);
        check("arst_any", any_expired, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        seen = 1'b0;
        for (int k = 0; k < 9; k++) begin
            do_tick();
            seen = seen | (|expired_pulse) | (|running) | (|expired);
        end
        check("arst_quiet", seen, 0);
        check("arst_cnt_after", cnt_of(1), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
